// File: rtl/mmio_stream_port.sv
// Purpose: 4-word MMIO window on the core bus bridging stores to a TX stream and an RX stream to loads.
// Latency: loads answer combinationally in the rd_en cycle; FIFO/flag state updates at the next edge, irq one edge after that.
// Backpressure: TX drains only on tx_valid & tx_ready; rx_ready drops while the RX FIFO is full or reset is high.
module mmio_stream_port #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        hit,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rx_ready,
  output logic        irq
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int RCW = RAW + 1;
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);

  logic [15:0]    tx_mem_q [TX_DEPTH];
  logic [15:0]    tx_mem_d [TX_DEPTH];
  logic [15:0]    rx_mem_q [RX_DEPTH];
  logic [15:0]    rx_mem_d [RX_DEPTH];
  logic [TAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [RAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RCW-1:0] rx_cnt_q, rx_cnt_d;
  logic           tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;
  logic           ien_tx_q, ien_tx_d, ien_rx_q, ien_rx_d;
  logic           irq_q, irq_d;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic rd_hit, wr_hit;
  logic tx_push_req, tx_push, tx_pop, rx_pop_req, rx_pop, rx_push;
  logic ctrl_wr, tx_flush, rx_flush, flag_clr;

  assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  // A simultaneous store is dropped so a combined rd/wr strobe acts as a plain load.
  assign hit    = (addr[15:2] == BASE_ADDR[15:2]) & (rd_en | wr_en);
  assign rd_hit = hit & rd_en;
  assign wr_hit = hit & wr_en & ~rd_en;

  assign tx_push_req = wr_hit & (addr[1:0] == 2'd0);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_valid    = ~tx_empty & ~reset;
  assign tx_data     = tx_valid ? tx_mem_q[tx_rd_q] : 16'h0000;
  assign tx_pop      = tx_valid & tx_ready;

  assign rx_pop_req = rd_hit & (addr[1:0] == 2'd1);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_ready   = ~rx_full & ~reset;
  assign rx_push    = rx_valid & rx_ready;

  assign ctrl_wr  = wr_hit & (addr[1:0] == 2'd3);
  assign tx_flush = ctrl_wr & write_data[0];
  assign rx_flush = ctrl_wr & write_data[1];
  assign flag_clr = ctrl_wr & write_data[2];

  assign irq = irq_q & ~reset;

  // Load data mux; zero on a miss or when no load is in progress.
  always_comb begin
    read_data = 16'h0000;
    if (rd_hit) begin
      case (addr[1:0])
        2'd1:    read_data = rx_empty ? 16'h0000 : rx_mem_q[rx_rd_q];
        2'd2:    read_data = {10'b0, rx_udf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
        2'd3:    read_data = {11'b0, ien_rx_q, ien_tx_q, 3'b0};
        default: read_data = 16'h0000;
      endcase
    end
  end

  // FIFO storage writes; contents need no reset since the counts gate visibility.
  always_comb begin
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    if (tx_push) tx_mem_d[tx_wr_q] = write_data;
    if (rx_push) rx_mem_d[rx_wr_q] = rx_data;
  end

  // Pointer, count, flag and irq next-state; a flush overrides same-cycle push/pop.
  always_comb begin
    tx_wr_d  = tx_wr_q;
    tx_rd_d  = tx_rd_q;
    tx_cnt_d = tx_cnt_q;
    rx_wr_d  = rx_wr_q;
    rx_rd_d  = rx_rd_q;
    rx_cnt_d = rx_cnt_q;
    ien_tx_d = ien_tx_q;
    ien_rx_d = ien_rx_q;

    if (tx_flush) begin
      tx_wr_d  = '0;
      tx_rd_d  = '0;
      tx_cnt_d = '0;
    end else begin
      if (tx_push) tx_wr_d = tx_wr_q + TAW'(1);
      if (tx_pop)  tx_rd_d = tx_rd_q + TAW'(1);
      if (tx_push & ~tx_pop)      tx_cnt_d = tx_cnt_q + TCW'(1);
      else if (~tx_push & tx_pop) tx_cnt_d = tx_cnt_q - TCW'(1);
    end

    if (rx_flush) begin
      rx_wr_d  = '0;
      rx_rd_d  = '0;
      rx_cnt_d = '0;
    end else begin
      if (rx_push) rx_wr_d = rx_wr_q + RAW'(1);
      if (rx_pop)  rx_rd_d = rx_rd_q + RAW'(1);
      if (rx_push & ~rx_pop)      rx_cnt_d = rx_cnt_q + RCW'(1);
      else if (~rx_push & rx_pop) rx_cnt_d = rx_cnt_q - RCW'(1);
    end

    // Setting wins over a same-cycle clear.
    tx_ovf_d = (tx_push_req & tx_full) | (tx_ovf_q & ~flag_clr);
    rx_udf_d = (rx_pop_req & rx_empty) | (rx_udf_q & ~flag_clr);

    if (ctrl_wr) begin
      ien_tx_d = write_data[3];
      ien_rx_d = write_data[4];
    end

    irq_d = (ien_rx_q & ~rx_empty) | (ien_tx_q & tx_empty);
  end

  // FIFO storage registers.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
      ien_tx_q <= 1'b0;
      ien_rx_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
      ien_tx_q <= ien_tx_d;
      ien_rx_q <= ien_rx_d;
      irq_q    <= irq_d;
    end
  end

endmodule
